// File: rtl/ras_ckpt.sv
// Circular return-address stack with saturating occupancy, overflow pulse and
// optional top-of-stack checkpoint/restore (enabled by defining RAS_CKPT_EN).
module ras_ckpt #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned VLEN  = 64
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [VLEN-1:0]              data_i,
    input  logic                         ckpt_save_i,
    input  logic                         ckpt_restore_i,
    output logic                         top_valid_o,
    output logic [VLEN-1:0]              top_addr_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         overflow_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [VLEN-1:0] entry_q [DEPTH];
    logic [PW-1:0]   tos_q, tos_d, tos_inc, tos_dec;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            is_full, is_empty;

    logic            wr_en;
    logic [PW-1:0]   wr_idx;
    logic [VLEN-1:0] wr_data;

    logic            restore_en;
    logic [PW-1:0]   snap_tos;
    logic [CW-1:0]   snap_count;
    logic [VLEN-1:0] snap_addr;

    // Explicit wrap keeps non-power-of-two depths inside 0..DEPTH-1.
    assign tos_inc  = (tos_q == PW'(DEPTH - 1)) ? '0 : tos_q + PW'(1);
    assign tos_dec  = (tos_q == '0) ? PW'(DEPTH - 1) : tos_q - PW'(1);
    assign is_full  = (count_q == CW'(DEPTH));
    assign is_empty = (count_q == '0);

`ifdef RAS_CKPT_EN
    logic            save_en;
    logic [VLEN-1:0] top_next;
    logic [PW-1:0]   snap_tos_q;
    logic [CW-1:0]   snap_count_q;
    logic [VLEN-1:0] snap_addr_q;

    assign restore_en = ckpt_restore_i;
    assign save_en    = ckpt_save_i & ~ckpt_restore_i;
    assign snap_tos   = snap_tos_q;
    assign snap_count = snap_count_q;
    assign snap_addr  = snap_addr_q;

    // The snapshot captures the post-update state, so forward this cycle's write.
    assign top_next = (wr_en && (wr_idx == tos_d)) ? wr_data : entry_q[tos_d];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            snap_tos_q   <= '0;
            snap_count_q <= '0;
            snap_addr_q  <= '0;
        end else if (save_en) begin
            snap_tos_q   <= tos_d;
            snap_count_q <= count_d;
            snap_addr_q  <= top_next;
        end
    end
`else
    logic unused_ckpt;

    assign unused_ckpt = ckpt_save_i | ckpt_restore_i;
    assign restore_en  = 1'b0;
    assign snap_tos    = '0;
    assign snap_count  = '0;
    assign snap_addr   = '0;
`endif

    always_comb begin
        tos_d   = tos_q;
        count_d = count_q;
        ovf_d   = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = tos_q;
        wr_data = data_i;
        if (flush_i) begin
            tos_d   = '0;
            count_d = '0;
        end else if (restore_en) begin
            tos_d   = snap_tos;
            count_d = snap_count;
            wr_en   = 1'b1;
            wr_idx  = snap_tos;
            wr_data = snap_addr;
        end else if (push_i && pop_i && !is_empty) begin
            wr_en = 1'b1;
        end else if (push_i) begin
            // On a full stack the incremented pointer lands on the oldest entry.
            tos_d  = tos_inc;
            wr_en  = 1'b1;
            wr_idx = tos_inc;
            if (is_full) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end else if (pop_i && !is_empty) begin
            tos_d   = tos_dec;
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tos_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            tos_q   <= tos_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entry_q[i] <= '0;
            end
        end else if (wr_en) begin
            entry_q[wr_idx] <= wr_data;
        end
    end

    assign top_valid_o = !is_empty;
    assign top_addr_o  = entry_q[tos_q];
    assign count_o     = count_q;
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_ras_ckpt.sv
// Bench for ras_ckpt: DEPTH=2 and DEPTH=3 instances driven in lockstep and
// compared against an unbounded-pointer stack model plus directed expectations.
module tb_ras_ckpt;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush, push, pop, save, restore;
    logic [63:0] data;

    logic        v2, v3, o2, o3;
    logic [63:0] a2, a3;
    logic [1:0]  c2, c3;

    int n_assert = 0;
    int n_fail   = 0;
    string phase = "init";

`ifdef RAS_CKPT_EN
    localparam bit CKPT = 1'b1;
`else
    localparam bit CKPT = 1'b0;
`endif

    always #5 clk = ~clk;

    ras_ckpt #(.DEPTH(2), .VLEN(64)) u_d2 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .push_i(push), .pop_i(pop),
        .data_i(data), .ckpt_save_i(save), .ckpt_restore_i(restore),
        .top_valid_o(v2), .top_addr_o(a2), .count_o(c2), .overflow_o(o2)
    );

    ras_ckpt #(.DEPTH(3), .VLEN(64)) u_d3 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .push_i(push), .pop_i(pop),
        .data_i(data), .ckpt_save_i(save), .ckpt_restore_i(restore),
        .top_valid_o(v3), .top_addr_o(a3), .count_o(c3), .overflow_o(o3)
    );

    // Model: absolute pointer p, slot = p mod DEPTH; snapshot holds top slot only.
    int          m_p[2], m_cnt[2], s_p[2], s_cnt[2];
    logic [63:0] m_mem[2][3];
    logic [63:0] s_addr[2];
    bit          m_ovf[2];

    function automatic int dep(int k);
        return (k == 0) ? 2 : 3;
    endfunction

    function automatic int slot(int k, int p);
        return ((p % dep(k)) + dep(k)) % dep(k);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_p[k] = 0; m_cnt[k] = 0; m_ovf[k] = 1'b0;
            s_p[k] = 0; s_cnt[k] = 0; s_addr[k] = '0;
            for (int i = 0; i < 3; i++) m_mem[k][i] = '0;
        end
    endtask

    task automatic model_one(int k, bit pu, bit po, bit fl, bit sv, bit rs, logic [63:0] d);
        int depth = dep(k);
        m_ovf[k] = 1'b0;
        if (fl) begin
            m_p[k] = 0; m_cnt[k] = 0;
        end else if (rs && CKPT) begin
            m_p[k] = s_p[k]; m_cnt[k] = s_cnt[k];
            m_mem[k][slot(k, m_p[k])] = s_addr[k];
        end else if (pu && po && m_cnt[k] > 0) begin
            m_mem[k][slot(k, m_p[k])] = d;
        end else if (pu) begin
            m_p[k] = m_p[k] + 1;
            m_mem[k][slot(k, m_p[k])] = d;
            if (m_cnt[k] == depth) m_ovf[k] = 1'b1;
            else m_cnt[k] = m_cnt[k] + 1;
        end else if (po && m_cnt[k] > 0) begin
            m_p[k] = m_p[k] - 1;
            m_cnt[k] = m_cnt[k] - 1;
        end
        if (CKPT && sv && !rs) begin
            s_p[k] = slot(k, m_p[k]); s_cnt[k] = m_cnt[k];
            s_addr[k] = m_mem[k][slot(k, m_p[k])];
        end
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s observed=%h expected=%h", phase, tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            logic        v, o;
            logic [63:0] a;
            logic [1:0]  c;
            string       pfx;
            v = (k == 0) ? v2 : v3;
            o = (k == 0) ? o2 : o3;
            a = (k == 0) ? a2 : a3;
            c = (k == 0) ? c2 : c3;
            pfx = $sformatf("d%0d", dep(k));
            chk({pfx, "_count"}, 64'(c), 64'(m_cnt[k]));
            chk({pfx, "_valid"}, 64'(v), 64'(m_cnt[k] != 0));
            chk({pfx, "_ovf"},   64'(o), 64'(m_ovf[k]));
            if (m_cnt[k] > 0) chk({pfx, "_top"}, a, m_mem[k][slot(k, m_p[k])]);
        end
    endtask

    task automatic step(bit pu, bit po, bit fl, bit sv, bit rs, logic [63:0] d);
        push = pu; pop = po; flush = fl; save = sv; restore = rs; data = d;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) model_one(k, pu, po, fl, sv, rs, d);
        push = 1'b0; pop = 1'b0; flush = 1'b0; save = 1'b0; restore = 1'b0;
        check_all();
    endtask

    task automatic do_push(logic [63:0] d); step(1, 0, 0, 0, 0, d); endtask
    task automatic do_pop();                step(0, 1, 0, 0, 0, '0); endtask
    task automatic do_flush();              step(0, 0, 1, 0, 0, '0); endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; push = 1'b0; pop = 1'b0;
        save = 1'b0; restore = 1'b0; data = '0;
        model_reset();
        #12;
        phase = "reset";
        chk("d2_top_rst", a2, 64'h0);
        chk("d3_top_rst", a3, 64'h0);
        check_all();
        #2 rst_n = 1'b1;
        @(negedge clk);

        phase = "basic";
        do_push(64'h100);
        do_push(64'h200);
        chk("d2_top_200", a2, 64'h200);
        chk("d2_cnt_2", 64'(c2), 64'd2);
        do_pop();
        chk("d2_top_100", a2, 64'h100);
        chk("d2_cnt_1", 64'(c2), 64'd1);
        do_pop();
        chk("d2_valid_0", 64'(v2), 64'd0);
        do_pop();
        chk("d2_cnt_empty_pop", 64'(c2), 64'd0);

        phase = "wrap";
        do_flush();
        do_push(64'hA); do_push(64'hB); do_push(64'hC); do_push(64'hD);
        chk("d3_ovf_pulse", 64'(o3), 64'd1);
        chk("d3_cnt_full", 64'(c3), 64'd3);
        chk("d3_top_d", a3, 64'hD);
        chk("d2_ovf_b2b", 64'(o2), 64'd1);
        do_pop();
        chk("d3_ovf_clear", 64'(o3), 64'd0);
        chk("d3_top_c", a3, 64'hC);
        do_pop();
        chk("d3_top_b", a3, 64'hB);
        do_pop();
        chk("d3_empty", 64'(v3), 64'd0);

        phase = "pushpop";
        do_flush();
        do_push(64'h40);
        step(1, 1, 0, 0, 0, 64'h80);
        chk("d3_top_80", a3, 64'h80);
        chk("d3_cnt_pp", 64'(c3), 64'd1);
        do_flush();
        step(1, 1, 0, 0, 0, 64'h90);
        chk("d2_top_90", a2, 64'h90);
        chk("d2_cnt_pp_empty", 64'(c2), 64'd1);

        phase = "flush";
        do_flush();
        do_push(64'h10); do_push(64'h20);
        step(1, 0, 1, 0, 0, 64'h30);
        chk("d3_cnt_flush", 64'(c3), 64'd0);
        chk("d3_valid_flush", 64'(v3), 64'd0);
        do_push(64'h50);
        chk("d3_top_50", a3, 64'h50);
        chk("d3_cnt_50", 64'(c3), 64'd1);

        phase = "ckpt";
        do_flush();
        do_push(64'h1); do_push(64'h2);
        step(0, 0, 0, 1, 0, '0);
        do_pop(); do_pop(); do_push(64'h7);
        step(0, 0, 0, 0, 1, '0);
        chk("d3_top_restore", a3, CKPT ? 64'h2 : 64'h7);
        chk("d3_cnt_restore", 64'(c3), CKPT ? 64'd2 : 64'd1);
        step(0, 0, 1, 0, 1, '0);
        chk("d3_cnt_rst_flush", 64'(c3), 64'd0);
        do_push(64'h9);
        step(0, 0, 0, 1, 1, '0);
        chk("d3_top_rs_sv", a3, CKPT ? 64'h2 : 64'h9);
        do_push(64'h5);
        step(0, 0, 0, 0, 1, '0);
        chk("d3_top_snap_kept", a3, CKPT ? 64'h2 : 64'h5);
        chk("d3_cnt_snap_kept", 64'(c3), 64'd2);

        phase = "async_rst";
        do_flush();
        do_push(64'hA1); do_push(64'hA2);
        chk("d2_cnt_pre_rst", 64'(c2), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("d2_top_async", a2, 64'h0);
        chk("d3_top_async", a3, 64'h0);
        check_all();
        #2 rst_n = 1'b1;
        do_pop();
        chk("d3_cnt_pop_after_rst", 64'(c3), 64'd0);
        step(0, 0, 0, 0, 1, '0);
        chk("d3_cnt_restore_unsaved", 64'(c3), 64'd0);

        phase = "random";
        for (int i = 0; i < 400; i++) begin
            bit fl, sv, rs, pu, po;
            fl = ($urandom_range(0, 99) < 3);
            rs = ($urandom_range(0, 99) < 8);
            sv = ($urandom_range(0, 99) < 15);
            pu = ($urandom_range(0, 99) < 50);
            po = ($urandom_range(0, 99) < 45);
            step(pu, po, fl, sv, rs, {$urandom, $urandom});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
